// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 gate-level mux.
// Drives the mux select lines and waits for the select path to settle before
// flagging the owner's data as valid. It also bounds how long one owner may keep
// the mux while other requesters are waiting.
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   req[3:0]    level requests, bit i = mux input i, held until done
//   grant[3:0]  one-hot current owner, 0 when none
//   grant_valid mux output settled and owned by grant
//   address0/1  mux select LSB/MSB (owner index)
module mux_rr_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2,  // legal 1..15
  parameter int unsigned MAX_HOLD      = 8   // legal 0..255, 0 = no limit
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic       address0,
  output logic       address1
);

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned SET_W   = 4;
  localparam int unsigned HOLD_W  = 8;

  typedef enum logic [1:0] {S_IDLE, S_SWITCH, S_OWN} state_t;

  state_t              r_state;
  logic [N_REQ-1:0]    r_grant;
  logic                r_valid;
  logic [PTR_W-1:0]    r_addr;
  logic [PTR_W-1:0]    r_ptr;
  logic [SET_W-1:0]    r_settle;
  logic [HOLD_W-1:0]   r_hold;

  logic [N_REQ-1:0]    w_mask;
  logic                w_any;
  logic [PTR_W-1:0]    w_win;
  logic                w_owner_req;
  logic                w_settled;
  logic                w_hold_done;

  // Candidates: while owning, the current owner is never eligible to win.
  assign w_mask      = (r_state == S_OWN) ? (req & ~r_grant) : req;
  assign w_any       = |w_mask;
  assign w_owner_req = |(req & r_grant);
  assign w_settled   = (r_settle == SET_W'(SETTLE_CYCLES - 1));
  // The count keeps running while nobody waits, so a late waiter still forces
  // rotation as soon as it appears once the hold budget is spent.
  assign w_hold_done = (MAX_HOLD != 0) && (r_hold >= HOLD_W'(MAX_HOLD - 1));

  // First set candidate bit searching ptr, ptr+1, ... (mod 4).
  always_comb begin
    w_win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_mask[r_ptr + PTR_W'(k)]) w_win = r_ptr + PTR_W'(k);
    end
  end

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_valid  <= 1'b0;
      r_addr   <= '0;
      r_ptr    <= '0;
      r_settle <= '0;
      r_hold   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state  <= S_SWITCH;
            r_grant  <= N_REQ'(1) << w_win;
            r_addr   <= w_win;
            r_ptr    <= w_win + PTR_W'(1);
            r_settle <= '0;
          end
        end
        S_SWITCH: begin
          if (!w_owner_req) begin
            r_state <= S_IDLE;
            r_grant <= '0;
          end else if (w_settled) begin
            r_state <= S_OWN;
            r_valid <= 1'b1;
            r_hold  <= '0;
          end else begin
            r_settle <= r_settle + SET_W'(1);
          end
        end
        S_OWN: begin
          if (!w_owner_req || (w_hold_done && w_any)) begin
            r_valid <= 1'b0;
            if (w_any) begin
              r_state  <= S_SWITCH;
              r_grant  <= N_REQ'(1) << w_win;
              r_addr   <= w_win;
              r_ptr    <= w_win + PTR_W'(1);
              r_settle <= '0;
            end else begin
              r_state <= S_IDLE;
              r_grant <= '0;
            end
          end else if (r_hold != {HOLD_W{1'b1}}) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign address0    = r_addr[0];
  assign address1    = r_addr[1];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random request traffic,
// each checked against a timestamp-based reference model of the arbiter.
module tb_mux_rr_arbiter;

  localparam int SETTLE   = 2;
  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic       address0;
  logic       address1;

  int errors = 0;
  int checks = 0;

  mux_rr_arbiter #(.SETTLE_CYCLES(SETTLE), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .grant(grant),
    .grant_valid(grant_valid), .address0(address0), .address1(address1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 settling, 2 owned; timing kept as edge stamps.
  int         m_phase, m_owner, m_ptr, m_edge, m_sel_e, m_own_e;
  logic [3:0] m_grant;
  logic       m_valid;
  logic [1:0] m_addr;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic m_select(input int w);
    m_owner = w;
    m_grant = 4'(1) << w;
    m_addr  = 2'(w);
    m_ptr   = (w + 1) % 4;
    m_sel_e = m_edge;
    m_phase = 1;
  endtask

  always @(posedge clk or negedge reset_n) begin : model
    int w;
    if (!reset_n) begin
      m_phase = 0; m_owner = -1; m_ptr = 0; m_edge = 0;
      m_grant = '0; m_valid = 1'b0; m_addr = '0;
    end else begin
      m_edge++;
      case (m_phase)
        0: begin
          w = pick(req, m_ptr);
          if (w >= 0) m_select(w);
        end
        1: begin
          if (!req[m_owner]) begin
            m_phase = 0; m_owner = -1; m_grant = '0;
          end else if (m_edge - m_sel_e == SETTLE) begin
            m_phase = 2; m_valid = 1'b1; m_own_e = m_edge;
          end
        end
        default: begin
          w = pick(req & ~m_grant, m_ptr);
          if (!req[m_owner]) begin
            m_valid = 1'b0;
            if (w >= 0) m_select(w);
            else begin m_phase = 0; m_owner = -1; m_grant = '0; end
          end else if (MAX_HOLD != 0 && (m_edge - m_own_e) >= MAX_HOLD && w >= 0) begin
            m_valid = 1'b0;
            m_select(w);
          end
        end
      endcase
    end
  end

  // Structural invariants sampled every cycle.
  logic [1:0] prev_addr = 2'b00;
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (grant_valid && !($onehot(grant) && grant[{address1, address0}])) begin
        errors++;
        $display("FAIL invariant_onehot: grant=%b addr=%b%b valid=1", grant, address1, address0);
      end
      checks++;
      if (grant_valid && ({address1, address0} != prev_addr)) begin
        errors++;
        $display("FAIL invariant_addr_change: addr %b -> %b%b with valid=1", prev_addr, address1, address0);
      end
    end
    prev_addr = {address1, address0};
  end

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 4'b1111;
    #12;
    checks++;
    if ({grant, grant_valid, address1, address0} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state: got g=%b v=%b a=%b%b need all 0", grant, grant_valid, address1, address0);
    end
    @(negedge clk);
    req = 4'b0000;
    reset_n = 1'b1;
  endtask

  // Single requester: select at E0, valid SETTLE edges later.
  task automatic test_single();
    logic [6:0] exp_o [3];
    exp_o[0] = {4'b0100, 1'b0, 2'b10};
    exp_o[1] = {4'b0100, 1'b0, 2'b10};
    exp_o[2] = {4'b0100, 1'b1, 2'b10};
    do_reset();
    req = 4'b0100;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      checks++;
      if ({grant, grant_valid, address1, address0} !== exp_o[e]) begin
        errors++;
        $display("FAIL single_E%0d: got %b need %b", e, {grant, grant_valid, address1, address0}, exp_o[e]);
      end
    end
  endtask

  task automatic test_rotation();
    int owners[$];
    int vcnt, low_cnt, idx;
    logic prev_v;
    int exp_own[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    vcnt = 0; low_cnt = 0; prev_v = 1'b0;
    for (int c = 0; c < 150 && owners.size() < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({grant, grant_valid, address1, address0} !== {m_grant, m_valid, m_addr}) begin
        errors++;
        $display("FAIL rotation_model c=%0d: got %b need %b", c, {grant, grant_valid, address1, address0}, {m_grant, m_valid, m_addr});
      end
      if (grant_valid && !prev_v) begin
        idx = -1;
        for (int b = 0; b < 4; b++) if (grant[b]) idx = b;
        if (owners.size() > 0) begin
          checks++;
          if (low_cnt != SETTLE) begin
            errors++;
            $display("FAIL rotation_gap: valid low %0d cycles need %0d", low_cnt, SETTLE);
          end
        end
        owners.push_back(idx);
      end
      if (grant_valid) begin vcnt++; low_cnt = 0; end
      else begin vcnt = 0; low_cnt++; end
      prev_v = grant_valid;
      req = 4'b1111;
      if (vcnt == 3) req = 4'b1111 & ~grant;
    end
    checks++;
    if (owners.size() != 5) begin
      errors++;
      $display("FAIL rotation_timeout: got %0d owners need 5", owners.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (owners[i] != exp_own[i]) begin
          errors++;
          $display("FAIL rotation_order[%0d]: got %0d need %0d", i, owners[i], exp_own[i]);
        end
      end
    end
  endtask

  task automatic test_forced_rotation();
    int own0, c, hold2;
    do_reset();
    req = 4'b0001;
    c = 0;
    while (!grant_valid && c < 20) begin @(posedge clk); #1; c++; end
    own0 = 1;
    req = 4'b0101;
    for (c = 0; c < 40 && grant === 4'b0001; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({grant, grant_valid, address1, address0} !== {m_grant, m_valid, m_addr}) begin
        errors++;
        $display("FAIL forced_model c=%0d: got %b need %b", c, {grant, grant_valid, address1, address0}, {m_grant, m_valid, m_addr});
      end
      if (grant_valid && grant === 4'b0001) own0++;
    end
    checks++;
    if (own0 != MAX_HOLD || grant !== 4'b0100) begin
      errors++;
      $display("FAIL forced_hold: got own=%0d grant=%b need own=%0d grant=0100", own0, grant, MAX_HOLD);
    end
    hold2 = 0;
    for (c = 0; c < 20 && hold2 < 3; c++) begin
      @(posedge clk); #1;
      if (grant_valid) hold2++;
    end
    req = 4'b0001;
    for (c = 0; c < 20 && !(grant_valid && grant === 4'b0001); c++) begin
      @(posedge clk); #1;
      checks++;
      if (grant_valid && grant !== 4'b0100 && grant !== 4'b0001) begin
        errors++;
        $display("FAIL forced_return_owner: got %b", grant);
      end
    end
    checks++;
    if (!(grant_valid && grant === 4'b0001)) begin
      errors++;
      $display("FAIL forced_return: got g=%b v=%b need g=0001 v=1", grant, grant_valid);
    end
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b0010;
    @(posedge clk); #1;
    checks++;
    if ({grant, address1, address0} !== 6'b0010_01) begin
      errors++;
      $display("FAIL abort_select: got g=%b a=%b%b need g=0010 a=01", grant, address1, address0);
    end
    req = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({grant, grant_valid, address1, address0} !== 7'b0000_0_01) begin
        errors++;
        $display("FAIL abort_c%0d: got %b need 0000001", c, {grant, grant_valid, address1, address0});
      end
    end
  endtask

  task automatic test_reset_mid_own();
    int c;
    do_reset();
    req = 4'b1000;
    c = 0;
    while (!grant_valid && c < 20) begin @(posedge clk); #1; c++; end
    checks++;
    if (!(grant_valid && grant === 4'b1000 && {address1, address0} === 2'b11)) begin
      errors++;
      $display("FAIL midreset_own: got g=%b v=%b need g=1000 v=1", grant, grant_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({grant, grant_valid, address1, address0} !== 7'b0) begin
      errors++;
      $display("FAIL midreset_immediate: got %b need 0000000", {grant, grant_valid, address1, address0});
    end
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b1001;
    @(posedge clk); #1;
    checks++;
    if ({grant, address1, address0} !== 6'b0001_00) begin
      errors++;
      $display("FAIL midreset_ptr: got g=%b a=%b%b need g=0001 a=00", grant, address1, address0);
    end
  endtask

  task automatic test_random();
    do_reset();
    req = 4'($urandom_range(0, 15));
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({grant, grant_valid, address1, address0} !== {m_grant, m_valid, m_addr}) begin
        errors++;
        $display("FAIL random_model c=%0d: got %b need %b", c, {grant, grant_valid, address1, address0}, {m_grant, m_valid, m_addr});
      end
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 400) == 0) begin
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_forced_rotation();
    test_abort();
    test_reset_mid_own();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
